// File: rtl/kevin_pkg.sv
// kevin_pkg
// Shared definitions for the Kevin-number sweep controller and its golden
// reference: sequencer state encoding, golden code table and datapath widths.
package kevin_pkg;

   localparam int CODE_W = 4;
   localparam int CNT_W  = 5;

   // Bit n set means code n is a Kevin number: {1,5,6,7,9,10,12,14}.
   localparam logic [15:0] KEVIN_MASK = 16'h56E2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Table lookup shared by the golden model and anything that needs it.
   function automatic logic kevin_lookup(input logic [15:0] mask,
                                         input logic [CODE_W-1:0] code);
      return mask[code];
   endfunction

endpackage

// File: rtl/kevin_golden.sv
// kevin_golden
// Combinational golden reference: maps a 4-bit code to its expected
// detector output using the Kevin table.
//   code     in  4  code under test
//   expected out 1  1 when code is a Kevin number
module kevin_golden
#(
   parameter logic [15:0] MASK = kevin_pkg::KEVIN_MASK
)
(
   input  logic [kevin_pkg::CODE_W-1:0] code,
   output logic                         expected
);
   import kevin_pkg::*;

   // Pure table lookup, no state.
   always_comb begin
      expected = kevin_lookup(MASK, code);
   end

endmodule

// File: rtl/kevin_sweep_ctrl.sv
// kevin_sweep_ctrl
// Sweeps the shared detector input over [lo, hi], waits SETTLE cycles per
// code, then compares the three detector outputs against the golden table
// and accumulates hit/error counts. start/done handshake; all outputs are
// registered.
//   clk, rst           clock, synchronous active-high reset
//   start, lo, hi      sweep request and inclusive code range
//   det_in             code driven to the detectors
//   out_g/out_d/out_b  gate-level, dataflow, behavioural detector outputs
//   busy, done         sweep in progress, one-cycle end-of-sweep pulse
//   hit_cnt, err_cnt   result counters
//   err_flag, first_err_in  sticky error flag and code of first error
module kevin_sweep_ctrl
#(
   parameter int unsigned SETTLE     = 1,
   parameter logic [15:0] KEVIN_MASK = kevin_pkg::KEVIN_MASK
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [kevin_pkg::CODE_W-1:0] lo,
   input  logic [kevin_pkg::CODE_W-1:0] hi,
   output logic [kevin_pkg::CODE_W-1:0] det_in,
   input  logic                         out_g,
   input  logic                         out_d,
   input  logic                         out_b,
   output logic                         busy,
   output logic                         done,
   output logic [kevin_pkg::CNT_W-1:0]  hit_cnt,
   output logic [kevin_pkg::CNT_W-1:0]  err_cnt,
   output logic                         err_flag,
   output logic [kevin_pkg::CODE_W-1:0] first_err_in
);
   import kevin_pkg::*;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   hi_q, hi_d;
   logic [CODE_W-1:0]   det_in_q, det_in_d;
   logic [3:0]          settle_q, settle_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic                err_flag_q, err_flag_d;
   logic [CODE_W-1:0]   first_err_q, first_err_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;

   logic                expected_s;
   logic                mismatch_s;
   logic                hit_s;

   kevin_golden #(.MASK(KEVIN_MASK)) u_golden (
      .code     (det_in_q),
      .expected (expected_s)
   );

   // Detector verdict for the code currently on det_in. Case equality makes
   // an X/Z output count as a mismatch and never as a hit.
   always_comb begin
      mismatch_s = (out_g !== expected_s) || (out_d !== expected_s) ||
                   (out_b !== expected_s);
      hit_s      = (expected_s === 1'b1) && (out_g === 1'b1) &&
                   (out_d === 1'b1) && (out_b === 1'b1);
   end

   // Next-state and next-output computation for the sweep sequencer.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      det_in_d    = det_in_q;
      settle_d    = settle_q;
      hit_cnt_d   = hit_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_flag_d  = err_flag_q;
      first_err_d = first_err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               hi_d        = hi;
               hit_cnt_d   = 5'd0;
               err_cnt_d   = 5'd0;
               err_flag_d  = 1'b0;
               first_err_d = 4'd0;
               if (lo > hi) begin
                  state_d = ST_DONE;
               end else begin
                  det_in_d = lo;
                  settle_d = SETTLE_C;
                  state_d  = ST_DRIVE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            settle_d = settle_q - 4'd1;
            // Last settle cycle when the counter is at 1 (<= guards against 0).
            if (settle_q <= 4'd1) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_DRIVE;
            end
         end
         ST_SAMPLE: begin
            if (mismatch_s) begin
               err_cnt_d = err_cnt_q + 5'd1;
               if (!err_flag_q) begin
                  err_flag_d  = 1'b1;
                  first_err_d = det_in_q;
               end else begin
                  first_err_d = first_err_q;
               end
            end else begin
               err_cnt_d = err_cnt_q;
            end
            if (hit_s) begin
               hit_cnt_d = hit_cnt_q + 5'd1;
            end else begin
               hit_cnt_d = hit_cnt_q;
            end
            // Terminate on equality so hi=15 never wraps det_in.
            if (det_in_q == hi_q) begin
               state_d = ST_DONE;
            end else begin
               det_in_d = det_in_q + 4'd1;
               settle_d = SETTLE_C;
               state_d  = ST_DRIVE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hi_q        <= 4'd0;
         det_in_q    <= 4'd0;
         settle_q    <= 4'd0;
         hit_cnt_q   <= 5'd0;
         err_cnt_q   <= 5'd0;
         err_flag_q  <= 1'b0;
         first_err_q <= 4'd0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         det_in_q    <= det_in_d;
         settle_q    <= settle_d;
         hit_cnt_q   <= hit_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_flag_q  <= err_flag_d;
         first_err_q <= first_err_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign det_in       = det_in_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign hit_cnt      = hit_cnt_q;
   assign err_cnt      = err_cnt_q;
   assign err_flag     = err_flag_q;
   assign first_err_in = first_err_q;

endmodule

// File: tb/tb_kevin_sweep_ctrl.sv
// tb_kevin_sweep_ctrl
// Directed bench for kevin_sweep_ctrl. Two instances: SETTLE=1 (with
// fault-injectable detector models) and SETTLE=3 (ideal detectors).
module tb_kevin_sweep_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] tb_mask;
   assign tb_mask = 16'h56E2;
   logic xv;
   assign xv = 1'bx;

   // SETTLE=1 instance
   logic       start1 = 1'b0;
   logic [3:0] lo1 = 4'd0, hi1 = 4'd0;
   logic [3:0] det1;
   logic       og1, od1, ob1;
   logic       busy1, done1, eflag1;
   logic [4:0] hit1, err1;
   logic [3:0] first1;
   int         fault_mode = 0;

   // SETTLE=3 instance
   logic       start3 = 1'b0;
   logic [3:0] lo3 = 4'd0, hi3 = 4'd0;
   logic [3:0] det3;
   logic       og3;
   logic       busy3, done3, eflag3;
   logic [4:0] hit3, err3;
   logic [3:0] first3;

   kevin_sweep_ctrl #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .lo(lo1), .hi(hi1),
      .det_in(det1), .out_g(og1), .out_d(od1), .out_b(ob1),
      .busy(busy1), .done(done1), .hit_cnt(hit1), .err_cnt(err1),
      .err_flag(eflag1), .first_err_in(first1)
   );

   kevin_sweep_ctrl #(.SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .lo(lo3), .hi(hi3),
      .det_in(det3), .out_g(og3), .out_d(og3), .out_b(og3),
      .busy(busy3), .done(done3), .hit_cnt(hit3), .err_cnt(err3),
      .err_flag(eflag3), .first_err_in(first3)
   );

   // Detector models for dut1 with optional faults.
   always_comb begin
      og1 = tb_mask[det1];
      od1 = tb_mask[det1];
      ob1 = tb_mask[det1];
      case (fault_mode)
         1: ob1 = 1'b0;
         2: od1 = 1'b1;
         3: if (det1 == 4'd6) og1 = xv;
         default: ;
      endcase
   end

   // Ideal detectors for dut3.
   always_comb og3 = tb_mask[det3];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_sweep(input bit sel, input logic [3:0] lo, input logic [3:0] hi,
                            input int fault, input bit restart,
                            input int e_hit, input int e_err, input int e_flag,
                            input int e_first, input int e_done, input string nm);
      int done_cnt, done_at, s, exp_det;
      bit det_ok, busy_ok;
      int a_det, a_busy, a_done;
      s = sel ? 3 : 1;
      @(negedge clk);
      fault_mode = fault;
      if (sel) begin lo3 = lo; hi3 = hi; start3 = 1'b1; end
      else     begin lo1 = lo; hi1 = hi; start1 = 1'b1; end
      @(posedge clk); // cycle-0 edge
      done_cnt = 0; done_at = -1; det_ok = 1'b1; busy_ok = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         a_det  = sel ? int'(det3) : int'(det1);
         a_busy = sel ? int'(busy3) : int'(busy1);
         a_done = sel ? int'(done3) : int'(done1);
         if (a_done == 1) begin done_cnt++; done_at = c; end
         if (a_busy != ((c <= e_done) ? 1 : 0)) busy_ok = 1'b0;
         if (lo <= hi) begin
            exp_det = (c < e_done) ? int'(lo) + (c - 1) / (s + 1) : int'(hi);
            if (a_det != exp_det) det_ok = 1'b0;
         end
         // Extra start pulses sampled at edges 3 and 5 must be ignored.
         if (sel) start3 = 1'b0;
         else     start1 = (restart && (c == 2 || c == 4)) ? 1'b1 : 1'b0;
      end
      chk({nm, "_done_count"}, done_cnt, 1);
      chk({nm, "_done_cycle"}, done_at, e_done);
      chk({nm, "_det_seq"}, int'(det_ok), 1);
      chk({nm, "_busy_seq"}, int'(busy_ok), 1);
      chk({nm, "_hit"}, sel ? int'(hit3) : int'(hit1), e_hit);
      chk({nm, "_err"}, sel ? int'(err3) : int'(err1), e_err);
      chk({nm, "_flag"}, sel ? int'(eflag3) : int'(eflag1), e_flag);
      if (e_flag == 1) chk({nm, "_first"}, sel ? int'(first3) : int'(first1), e_first);
   endtask

   typedef struct {
      logic [3:0] lo;
      logic [3:0] hi;
      int fault;
      int hit;
      int err;
      int flag;
      int first;
      int done_cyc;
      string nm;
   } vec_t;

   vec_t vt[6];

   initial begin
      int dcnt;
      int xh, xe, xf;
      // lo, hi, fault, hit, err, flag, first, done cycle
      vt[0] = '{4'd0,  4'd15, 0, 8, 0, 0, 0, 33, "full_ok"};
      vt[1] = '{4'd0,  4'd15, 1, 0, 8, 1, 1, 33, "b_stuck0"};
      vt[2] = '{4'd0,  4'd15, 2, 8, 8, 1, 0, 33, "d_stuck1"};
      vt[3] = '{4'd10, 4'd3,  0, 0, 0, 0, 0, 1,  "empty"};
      vt[4] = '{4'd15, 4'd15, 0, 0, 0, 0, 0, 3,  "only15"};
      vt[5] = '{4'd0,  4'd0,  0, 0, 0, 0, 0, 3,  "only0"};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_det", int'(det1), 0);
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_hit", int'(hit1), 0);
      chk("rst_err", int'(err1), 0);
      chk("rst_flag", int'(eflag1), 0);
      chk("rst_first", int'(first1), 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_sweep(1'b0, vt[i].lo, vt[i].hi, vt[i].fault, 1'b0, vt[i].hit,
                   vt[i].err, vt[i].flag, vt[i].first, vt[i].done_cyc, vt[i].nm);

      // Longer settle window, single code then empty range.
      run_sweep(1'b1, 4'd9, 4'd9, 0, 1'b0, 1, 0, 0, 0, 5, "s3_single");
      run_sweep(1'b1, 4'd10, 4'd3, 0, 1'b0, 0, 0, 0, 0, 1, "s3_empty");

      // Starts during a sweep are ignored.
      run_sweep(1'b0, 4'd0, 4'd15, 0, 1'b1, 8, 0, 0, 0, 33, "restart_ign");

      // Unknown on out_g at code 6; the expectation follows what the
      // simulator actually holds for the injected value.
      if (xv === 1'b1) begin xh = 3; xe = 0; xf = 0; end
      else begin xh = 2; xe = 1; xf = 1; end
      run_sweep(1'b0, 4'd4, 4'd8, 3, 1'b0, xh, xe, xf, 6, 11, "g_x6");

      // Reset mid-sweep: rst high in cycle 10, sampled at edge 11.
      fault_mode = 0;
      @(negedge clk);
      lo1 = 4'd0; hi1 = 4'd15; start1 = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start1 = 1'b0;
      end
      chk("pre_rst_hit", int'(hit1), 1);
      chk("pre_rst_busy", int'(busy1), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_det", int'(det1), 0);
      chk("mid_rst_busy", int'(busy1), 0);
      chk("mid_rst_done", int'(done1), 0);
      chk("mid_rst_hit", int'(hit1), 0);
      chk("mid_rst_err", int'(err1), 0);
      dcnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done1 == 1'b1 || busy1 == 1'b1) dcnt++;
      end
      chk("post_rst_quiet", dcnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
